mips_mdu: RTL

- Iterative multiply/divide unit for the 32-bit MIPS core, in the EX stage directly downstream of the register file.
- Consumes the two register-file read ports (rdout1 -> rs_data, rdout2 -> rt_data).
- Executes MULT/MULTU/DIV/DIVU over multiple cycles into private HI/LO registers. Also services MTHI/MTLO.
- Drives busy so the pipeline control can stall on MFHI/MFLO and on new MDU ops.

---
 rtl/mips_mdu.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mips_mdu.sv
// Iterative MIPS multiply/divide unit: MULT/MULTU/DIV/DIVU into private HI/LO, plus MTHI/MTLO.
// Define MDU_DIVIDE_EN to build the restoring divider; without it DIV/DIVU are ignored.
module mips_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier being consumed / dividend turning into quotient
    logic [WIDTH-1:0] bop;      // |multiplicand| or |divisor|
    logic             neg;      // product or quotient sign

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op && rs_data[WIDTH-1];
        b_neg     = signed_op && rt_data[WIDTH-1];
        a_abs     = a_neg ? -rs_data : rs_data;
        b_abs     = b_neg ? -rt_data : rt_data;
    end

    // Shift-add: add multiplicand into the high half when the current multiplier bit is set, then shift right.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, bop} : '0);
        mul_next = {mul_sum, acc_lo[WIDTH-1:1]};
        prod_fix = neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    end

`ifdef MDU_DIVIDE_EN
    logic           is_div;
    logic           div_zero;
    logic           neg_r;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;

    // Remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits.
    always_comb begin
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, bop};
    end
`endif

    assign busy = (state == ITER) || (state == FIX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            bop    <= '0;
            neg    <= 1'b0;
`ifdef MDU_DIVIDE_EN
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi <= rs_data;
                            OP_MTLO: lo <= rs_data;
                            OP_MULT, OP_MULTU: begin
                                acc_hi <= '0;
                                acc_lo <= a_abs;
                                bop    <= b_abs;
                                neg    <= a_neg ^ b_neg;
                                cnt    <= '0;
                                state  <= ITER;
`ifdef MDU_DIVIDE_EN
                                is_div   <= 1'b0;
                                div_zero <= 1'b0;
`endif
                            end
`ifdef MDU_DIVIDE_EN
                            OP_DIV, OP_DIVU: begin
                                is_div <= 1'b1;
                                neg    <= a_neg ^ b_neg;
                                neg_r  <= a_neg;
                                cnt    <= '0;
                                bop    <= b_abs;
                                if (rt_data == '0) begin
                                    div_zero <= 1'b1;
                                    acc_hi   <= rs_data;
                                    state    <= FIX;
                                end else begin
                                    div_zero <= 1'b0;
                                    acc_hi   <= '0;
                                    acc_lo   <= a_abs;
                                    state    <= ITER;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                ITER: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
`ifdef MDU_DIVIDE_EN
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc_hi <= div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi, acc_lo} <= mul_next;
                    end
`else
                    {acc_hi, acc_lo} <= mul_next;
`endif
                end
                FIX: begin
                    state <= IDLE;
                    done  <= 1'b1;
`ifdef MDU_DIVIDE_EN
                    if (is_div) begin
                        if (div_zero) begin
                            lo <= '1;
                            hi <= acc_hi;
                        end else begin
                            lo <= neg ? -acc_lo : acc_lo;
                            hi <= neg_r ? -acc_hi : acc_hi;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
`else
                    {hi, lo} <= prod_fix;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
